bit_unstuff: RTL and testbench
==============================

Name: bit_unstuff

Overview:
- Receive-side counterpart of the transmit bit stuffer: removes the stuffed zero that follows every run of MAX_ONES consecutive one bits.
- Flags a bit-stuff violation (a one where a stuffed zero is required).
- Sits between the receive NRZI decoder/sampler and the receive shift register.
- Its data_valid drives the shift register's shift enable; its stuff_drop output lets the byte/timer logic account for removed bits.

Parameters:
- MAX_ONES, 6: number of consecutive accepted ones after which the next sampled bit is a stuff bit.
- CNT_BITS, 3: width of the ones counter; must satisfy 2^CNT_BITS > MAX_ONES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sample_valid  input  1  one-cycle strobe, data_in holds a new decoded bit
- data_in  input  1  decoded (NRZI-removed) receive bit
- packet_active  input  1  high for the duration of a packet; low returns block to IDLE
- data_out  output  1  unstuffed data bit, qualified by data_valid
- data_valid  output  1  one-cycle pulse, data_out is a real payload bit
- stuff_drop  output  1  one-cycle pulse, a stuffed zero was removed
- stuff_error  output  1  sticky bit-stuff violation flag
- ones_count  output  CNT_BITS  current consecutive-ones count (debug/verification)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: data_out=0, data_valid=0, stuff_drop=0, stuff_error=0, ones_count=0, state=IDLE.
- Priority: rst > packet_active low > sample_valid.
- Latency: outputs update on the clock edge that samples sample_valid=1, so they are visible 1 cycle after the strobe.
- data_valid and stuff_drop are never high in the same cycle. Both are 0 in any cycle that follows sample_valid=0.
- IDLE:
  - ones_count=0, no outputs pulse.
  - packet_active=1 -> RUN, taking effect the same cycle, so a sample_valid arriving with the first packet_active=1 cycle is processed as RUN.
- RUN, on sample_valid:
  - data_out<=data_in, data_valid<=1.
  - data_in=0: ones_count<=0.
  - data_in=1 with ones_count<MAX_ONES-1: ones_count increments.
  - data_in=1 with ones_count==MAX_ONES-1: ones_count<=0, next state STUFF. The bit itself is still output.
- STUFF, on sample_valid:
  - data_in=0: stuff_drop<=1, data_valid<=0, next state RUN.
  - data_in=1: stuff_error<=1, data_valid<=0, next state ERR.
- STUFF without sample_valid: hold the state indefinitely.
- ERR:
  - Ignore all samples. No data_valid, no stuff_drop.
  - stuff_error stays 1.
- packet_active=0 in any state -> IDLE on the next edge:
  - ones_count<=0, stuff_error<=0, data_valid<=0, stuff_drop<=0.
  - A sample_valid in that same cycle is discarded.
- The counter never wraps. Its maximum held value is MAX_ONES-1, because the transition to STUFF resets it.
- rst mid-packet returns to the reset state immediately. A partial run of ones is forgotten.

Optional Feature:
- Macro: BIT_UNSTUFF_NRZI_DECODE_EN.
- Defined:
  - data_in is treated as the raw sampled line level, and the block performs NRZI decode internally.
  - decoded bit = 1 when the level equals the previous sampled level, 0 when it differs.
  - The previous-level register updates only on sample_valid.
  - It is set to 1 (idle J) on rst and while packet_active=0.
  - The decoded bit feeds the same unstuff state machine. This adds no extra latency: decode is combinational into the registered stage.
- Undefined: data_in is already decoded, and no previous-level register exists.

Test Plan:
- Reset: hold rst=1 for 2 cycles with sample_valid=1, data_in=1 -> data_valid=0, stuff_drop=0, stuff_error=0, ones_count=0.
- Normal unstuff: packet_active=1, sample_valid every cycle, data_in=1,1,1,1,1,1,0,1 -> data_valid pulses 6 times with data_out=1, then stuff_drop=1 with data_valid=0 for the 0, then data_valid=1 with data_out=1; ones_count=1 at the end.
- Violation: seven consecutive ones -> six data_valid pulses, then stuff_error=1 the cycle after the 7th sample. Further samples give no data_valid/stuff_drop. Dropping packet_active clears stuff_error next cycle.
- Run broken early: data_in=1,1,1,1,1,0,1,1 -> eight data_valid pulses, no stuff_drop; ones_count=2 at the end.
- Gapped strobes: six ones with sample_valid high every 4th cycle, then 0 -> ones_count holds between strobes; outputs pulse only the cycle after each strobe; stuff_drop on the 7th strobe.
- Abort mid-run: five ones, packet_active=0 for 1 cycle, re-raise, then six ones and a 0 -> no drop after the first eleven ones total; stuff_drop only on the final 0.

Source files
------------

// File: rtl/bit_unstuff.sv
// bit_unstuff
//   Receive-side bit unstuffer. After MAX_ONES consecutive accepted ones, the
//   next sampled bit must be a stuffed zero. That zero is removed and reported
//   on stuff_drop. A one in that slot is a bit-stuff violation: stuff_error is
//   set and stays set until the packet ends.
//
//   Optional feature macro: BIT_UNSTUFF_NRZI_DECODE_EN
//     When defined, data_in is the raw line level and NRZI decode happens here.
//     A bit decodes as 1 when the level matches the previous sampled level,
//     and as 0 when it differs. The previous level is 1 (idle J) after rst and
//     while packet_active is low.
//     When undefined, data_in is already decoded.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   sample_valid  one-cycle strobe: data_in holds a new bit
//   data_in       decoded receive bit (raw line level with NRZI decode enabled)
//   packet_active high for the packet; low returns the block to IDLE
//   data_out      unstuffed data bit, qualified by data_valid
//   data_valid    one-cycle pulse: data_out is a payload bit
//   stuff_drop    one-cycle pulse: a stuffed zero was removed
//   stuff_error   sticky bit-stuff violation flag
//   ones_count    current consecutive-ones count
module bit_unstuff #(
  parameter int MAX_ONES = 6,
  parameter int CNT_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic                data_in,
  input  logic                packet_active,
  output logic                data_out,
  output logic                data_valid,
  output logic                stuff_drop,
  output logic                stuff_error,
  output logic [CNT_BITS-1:0] ones_count
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MAX_ONES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, STUFF, ERR} state_t;

  state_t                state;
  state_t                state_eff;
  state_t                state_nxt;
  logic                  bit_in;
  logic                  dout_nxt;
  logic                  dv_nxt;
  logic                  sd_nxt;
  logic                  err_nxt;
  logic [CNT_BITS-1:0]   cnt_nxt;

`ifdef BIT_UNSTUFF_NRZI_DECODE_EN
  logic prev_level;

  function automatic logic nrzi_decode(input logic level, input logic prev);
    return (level == prev);
  endfunction

  assign bit_in = nrzi_decode(data_in, prev_level);

  always_ff @(posedge clk) begin
    if (rst || !packet_active) begin
      prev_level <= 1'b1;
    end else if (sample_valid) begin
      prev_level <= data_in;
    end
  end
`else
  assign bit_in = data_in;
`endif

  // IDLE becomes RUN in the same cycle packet_active rises. This way a strobe
  // that arrives with the first active cycle is unstuffed normally.
  always_comb begin
    state_eff = state;
    if (state == IDLE) begin
      state_eff = RUN;
    end
  end

  always_comb begin
    state_nxt = state_eff;
    dout_nxt  = data_out;
    dv_nxt    = 1'b0;
    sd_nxt    = 1'b0;
    err_nxt   = stuff_error;
    cnt_nxt   = ones_count;
    if (!packet_active) begin
      // End of packet: any sample in this cycle is discarded.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
    end else if (sample_valid) begin
      case (state_eff)
        RUN: begin
          dout_nxt = bit_in;
          dv_nxt   = 1'b1;
          if (!bit_in) begin
            cnt_nxt = '0;
          end else if (ones_count == CNT_LAST) begin
            // This one is still payload. The next sampled bit is the stuff slot.
            cnt_nxt   = '0;
            state_nxt = STUFF;
          end else begin
            cnt_nxt = ones_count + CNT_ONE;
          end
        end
        STUFF: begin
          if (!bit_in) begin
            sd_nxt    = 1'b1;
            state_nxt = RUN;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERR;
          end
        end
        default: begin
          // ERR ignores all samples until packet_active drops.
        end
      endcase
    end
  end

  // Registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
      stuff_drop  <= 1'b0;
      stuff_error <= 1'b0;
      ones_count  <= '0;
    end else begin
      state       <= state_nxt;
      data_out    <= dout_nxt;
      data_valid  <= dv_nxt;
      stuff_drop  <= sd_nxt;
      stuff_error <= err_nxt;
      ones_count  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bit_unstuff.sv
module tb_bit_unstuff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic       data_in = 1'b0;
  logic       packet_active = 1'b0;
  logic       data_out;
  logic       data_valid;
  logic       stuff_drop;
  logic       stuff_error;
  logic [2:0] ones_count;

  int tests = 0;
  int fails = 0;

  // Expected output events: 0/1 = payload bit value, 2 = stuff drop
  int exp_q[$];

  bit_unstuff #(.MAX_ONES(6), .CNT_BITS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .data_in      (data_in),
    .packet_active(packet_active),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .stuff_drop   (stuff_drop),
    .stuff_error  (stuff_error),
    .ones_count   (ones_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT pulses an output
  always @(negedge clk) begin
    if (data_valid && stuff_drop) begin
      chk("dv_and_drop_exclusive", 1, 0);
    end else if (data_valid || stuff_drop) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_event", stuff_drop ? 2 : int'(data_out), -1);
      end else begin
        chk("output_event", stuff_drop ? 2 : int'(data_out), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe, then gap idle cycles. On return (gap=0) the outputs already
  // reflect this sample.
  task automatic sample(input logic b, input int gap);
    packet_active = 1'b1;
    sample_valid  = 1'b1;
    data_in       = b;
    tick();
    sample_valid  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic end_packet(input string name);
    sample_valid  = 1'b0;
    packet_active = 1'b0;
    tick();
    tick();
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset: strobes with ones while rst is high must be ignored
    rst = 1'b1; packet_active = 1'b1; sample_valid = 1'b1; data_in = 1'b1;
    tick(); tick();
    chk("rst_data_valid",  data_valid,  0);
    chk("rst_stuff_drop",  stuff_drop,  0);
    chk("rst_stuff_error", stuff_error, 0);
    chk("rst_ones_count",  ones_count,  0);
    rst = 1'b0; sample_valid = 1'b0; packet_active = 1'b0;
    tick();

    // Normal unstuff: 1x6, stuffed 0, 1
    for (int i = 0; i < 6; i++) begin exp_q.push_back(1); sample(1'b1, 0); end
    chk("norm_cnt_after_six", ones_count, 0);
    exp_q.push_back(2); sample(1'b0, 0);
    exp_q.push_back(1); sample(1'b1, 0);
    chk("norm_cnt_end", ones_count, 1);
    chk("norm_no_error", stuff_error, 0);
    end_packet("norm");

    // Violation: seven ones
    for (int i = 0; i < 6; i++) begin exp_q.push_back(1); sample(1'b1, 0); end
    chk("viol_err_before", stuff_error, 0);
    sample(1'b1, 0);
    chk("viol_err_set", stuff_error, 1);
    sample(1'b0, 0);
    sample(1'b1, 0);
    sample(1'b0, 0);
    chk("viol_err_sticky", stuff_error, 1);
    packet_active = 1'b0;
    tick();
    chk("viol_err_cleared", stuff_error, 0);
    chk("viol_cnt_cleared", ones_count, 0);
    end_packet("viol");

    // Run broken early: 1,1,1,1,1,0,1,1
    for (int i = 0; i < 5; i++) begin exp_q.push_back(1); sample(1'b1, 0); end
    chk("brk_cnt_five", ones_count, 5);
    exp_q.push_back(0); sample(1'b0, 0);
    chk("brk_cnt_zero", ones_count, 0);
    exp_q.push_back(1); sample(1'b1, 0);
    exp_q.push_back(1); sample(1'b1, 0);
    chk("brk_cnt_end", ones_count, 2);
    end_packet("brk");

    // Gapped strobes: one strobe every 4th cycle
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(1);
      sample(1'b1, 0);
      if (i < 5) chk("gap_cnt_after_strobe", ones_count, i + 1);
      tick(); tick(); tick();
      if (i < 5) chk("gap_cnt_held", ones_count, i + 1);
    end
    exp_q.push_back(2); sample(1'b0, 3);
    chk("gap_cnt_end", ones_count, 0);
    end_packet("gap");

    // Abort mid-run: 5 ones, one idle cycle, then 6 ones and a 0.
    // The strobe while packet_active is low must be discarded.
    for (int i = 0; i < 5; i++) begin exp_q.push_back(1); sample(1'b1, 0); end
    chk("abort_cnt_five", ones_count, 5);
    packet_active = 1'b0; sample_valid = 1'b1; data_in = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("abort_cnt_cleared", ones_count, 0);
    for (int i = 0; i < 6; i++) begin exp_q.push_back(1); sample(1'b1, 0); end
    exp_q.push_back(2); sample(1'b0, 0);
    chk("abort_no_error", stuff_error, 0);
    end_packet("abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
